// File: rtl/seq_divider.sv
// -----------------------------------------------------------------------------
// seq_divider
// Iterative radix-2 restoring divider producing one quotient bit per clock.
// Handles signed (two's-complement) or unsigned operands; the sign is removed
// up front, the magnitudes are divided, and the signs are restored at the end.
// Division truncates toward zero and the remainder follows the dividend's sign.
//
// Optional build macro: DIV_EARLY_EXIT_EN
//   When defined, an operation whose divisor magnitude exceeds the dividend
//   magnitude skips the iteration phase (quotient 0, remainder = dividend).
//   Results are identical either way; only latency changes.
//
// Ports:
//   clk          in   clock, all state updates on the rising edge
//   reset        in   synchronous active-high reset, aborts any operation
//   start        in   request, sampled only while idle
//   is_signed    in   1 = two's-complement operands, captured with start
//   dividend     in   [WIDTH-1:0] captured on accepted start
//   divisor      in   [WIDTH-1:0] captured on accepted start
//   busy         out  high from the edge after start is accepted until done
//   done         out  one-cycle pulse, results valid then and held afterwards
//   quotient     out  [WIDTH-1:0] result quotient
//   remainder    out  [WIDTH-1:0] result remainder
//   div_by_zero  out  set with done when the divisor was zero, held with results
// -----------------------------------------------------------------------------
module seq_divider #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
    localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] ONE_W = {{(WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PREP = 2'd1,
        CALC = 2'd2,
        FIX  = 2'd3
    } state_t;

    // Two's-complement negate when neg is set, pass-through otherwise.
    function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] v,
                                                  input logic             neg);
        cond_neg = neg ? (~v + ONE_W) : v;
    endfunction

    state_t           state_r;
    logic [WIDTH-1:0] dvd_raw_r;   // dividend as captured
    logic [WIDTH-1:0] dvs_raw_r;   // divisor as captured
    logic             signed_r;
    logic [WIDTH-1:0] q_r;         // dividend magnitude shifting out, quotient shifting in
    logic [WIDTH-1:0] rem_r;       // partial remainder (always < divisor magnitude)
    logic [WIDTH-1:0] dvs_mag_r;
    logic             neg_q_r;
    logic             neg_rem_r;
    logic             dbz_r;
    logic [CW-1:0]    count_r;

    logic             dvd_neg_s;
    logic             dvs_neg_s;
    logic [WIDTH-1:0] dvd_mag_s;
    logic [WIDTH-1:0] dvs_mag_s;
    logic             dvs_zero_s;
    logic             early_s;
    logic [WIDTH:0]   shifted_s;
    logic [WIDTH:0]   trial_s;

    assign dvd_neg_s  = signed_r & dvd_raw_r[WIDTH-1];
    assign dvs_neg_s  = signed_r & dvs_raw_r[WIDTH-1];
    assign dvd_mag_s  = cond_neg(dvd_raw_r, dvd_neg_s);
    assign dvs_mag_s  = cond_neg(dvs_raw_r, dvs_neg_s);
    assign dvs_zero_s = (dvs_raw_r == {WIDTH{1'b0}});

`ifdef DIV_EARLY_EXIT_EN
    assign early_s = (dvs_mag_s > dvd_mag_s);
`else
    assign early_s = 1'b0;
`endif

    // The shifted remainder is below twice the divisor magnitude, so a
    // WIDTH+1 bit difference is exact and its MSB is the borrow/sign.
    assign shifted_s = {rem_r, q_r[WIDTH-1]};
    assign trial_s   = shifted_s - {1'b0, dvs_mag_r};

    // Control FSM, datapath registers and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= IDLE;
            dvd_raw_r   <= {WIDTH{1'b0}};
            dvs_raw_r   <= {WIDTH{1'b0}};
            signed_r    <= 1'b0;
            q_r         <= {WIDTH{1'b0}};
            rem_r       <= {WIDTH{1'b0}};
            dvs_mag_r   <= {WIDTH{1'b0}};
            neg_q_r     <= 1'b0;
            neg_rem_r   <= 1'b0;
            dbz_r       <= 1'b0;
            count_r     <= {CW{1'b0}};
            busy        <= 1'b0;
            done        <= 1'b0;
            quotient    <= {WIDTH{1'b0}};
            remainder   <= {WIDTH{1'b0}};
            div_by_zero <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (start) begin
                        dvd_raw_r <= dividend;
                        dvs_raw_r <= divisor;
                        signed_r  <= is_signed;
                        busy      <= 1'b1;
                        state_r   <= PREP;
                    end else begin
                        state_r   <= IDLE;
                    end
                end
                PREP: begin
                    rem_r     <= {WIDTH{1'b0}};
                    count_r   <= {CW{1'b0}};
                    q_r       <= dvd_mag_s;
                    dvs_mag_r <= dvs_mag_s;
                    neg_q_r   <= dvd_neg_s ^ dvs_neg_s;
                    neg_rem_r <= dvd_neg_s;
                    dbz_r     <= 1'b0;
                    // Bypass paths preload the final values with no sign fix-up.
                    if (dvs_zero_s) begin
                        q_r       <= {WIDTH{1'b1}};
                        rem_r     <= dvd_raw_r;
                        neg_q_r   <= 1'b0;
                        neg_rem_r <= 1'b0;
                        dbz_r     <= 1'b1;
                        state_r   <= FIX;
                    end else if (early_s) begin
                        q_r       <= {WIDTH{1'b0}};
                        rem_r     <= dvd_raw_r;
                        neg_q_r   <= 1'b0;
                        neg_rem_r <= 1'b0;
                        state_r   <= FIX;
                    end else begin
                        state_r   <= CALC;
                    end
                end
                CALC: begin
                    rem_r   <= trial_s[WIDTH] ? shifted_s[WIDTH-1:0] : trial_s[WIDTH-1:0];
                    q_r     <= {q_r[WIDTH-2:0], ~trial_s[WIDTH]};
                    count_r <= count_r + CNT_ONE;
                    if (count_r == CNT_LAST) begin
                        state_r <= FIX;
                    end else begin
                        state_r <= CALC;
                    end
                end
                FIX: begin
                    quotient    <= cond_neg(q_r, neg_q_r);
                    remainder   <= cond_neg(rem_r, neg_rem_r);
                    div_by_zero <= dbz_r;
                    done        <= 1'b1;
                    busy        <= 1'b0;
                    state_r     <= IDLE;
                end
                default: begin
                    state_r <= IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_divider.sv
// -----------------------------------------------------------------------------
// tb_seq_divider
// Self-checking bench for seq_divider (WIDTH = 32). A transaction-level model
// computes each result with plain integer division and predicts the done time
// as a fixed latency; a compare process checks every output on every cycle
// against that model, and directed vectors check literal expected values.
// -----------------------------------------------------------------------------
module tb_seq_divider;

`ifdef DIV_EARLY_EXIT_EN
    localparam bit EARLY = 1'b1;
    localparam int EL    = 2;
`else
    localparam bit EARLY = 1'b0;
    localparam int EL    = 34;
`endif

    typedef struct packed {
        logic [31:0] q;
        logic [31:0] r;
        logic        dz;
        logic [7:0]  lat;
    } res_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        is_signed;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        busy;
    logic        done;
    logic [31:0] quotient;
    logic [31:0] remainder;
    logic        div_by_zero;

    int n_vec = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    seq_divider #(.WIDTH(32)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .is_signed  (is_signed),
        .dividend   (dividend),
        .divisor    (divisor),
        .busy       (busy),
        .done       (done),
        .quotient   (quotient),
        .remainder  (remainder),
        .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    // Reference result: integer division truncating toward zero.
    function automatic res_t model_div(input logic [31:0] a, input logic [31:0] b,
                                       input logic s);
        res_t   x;
        longint sa, sb, ma, mb, t;
        sa = s ? longint'($signed(a)) : longint'({32'd0, a});
        sb = s ? longint'($signed(b)) : longint'({32'd0, b});
        ma = (sa < 0) ? -sa : sa;
        mb = (sb < 0) ? -sb : sb;
        if (b == 32'd0) begin
            x.q   = 32'hFFFF_FFFF;
            x.r   = a;
            x.dz  = 1'b1;
            x.lat = 8'd2;
        end else begin
            t     = sa / sb;
            x.q   = t[31:0];
            t     = sa % sb;
            x.r   = t[31:0];
            x.dz  = 1'b0;
            x.lat = (EARLY && (mb > ma)) ? 8'd2 : 8'd34;
        end
        return x;
    endfunction

    // Cycle-level expectation of the outputs.
    logic        m_busy, m_done, m_dz, m_active;
    logic [31:0] m_q, m_r;
    logic [7:0]  m_cnt;
    res_t        p_res;

    always @(posedge clk) begin
        if (reset) begin
            m_busy   <= 1'b0;
            m_done   <= 1'b0;
            m_dz     <= 1'b0;
            m_q      <= 32'd0;
            m_r      <= 32'd0;
            m_active <= 1'b0;
            m_cnt    <= 8'd0;
        end else begin
            m_done <= 1'b0;
            if (m_active) begin
                if (m_cnt == p_res.lat) begin
                    m_done   <= 1'b1;
                    m_busy   <= 1'b0;
                    m_q      <= p_res.q;
                    m_r      <= p_res.r;
                    m_dz     <= p_res.dz;
                    m_active <= 1'b0;
                end else begin
                    m_cnt <= m_cnt + 8'd1;
                end
            end else if (start) begin
                p_res    <= model_div(dividend, divisor, is_signed);
                m_active <= 1'b1;
                m_cnt    <= 8'd1;
                m_busy   <= 1'b1;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, want, $time);
        end
    endtask

    // Per-cycle comparison of every output against the model.
    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                chk("cyc_busy", {31'd0, busy}, {31'd0, m_busy});
                chk("cyc_done", {31'd0, done}, {31'd0, m_done});
                chk("cyc_q", quotient, m_q);
                chk("cyc_r", remainder, m_r);
                chk("cyc_dz", {31'd0, div_by_zero}, {31'd0, m_dz});
            end
        end
    end

    // Issue one operation from the current negedge and check its result and
    // latency; glitch_k >= 0 pulses start with other operands mid-operation.
    task automatic run_op(input string name, input logic [31:0] a, input logic [31:0] b,
                          input logic s, input logic [31:0] eq, input logic [31:0] er,
                          input logic edz, input int elat, input int glitch_k);
        res_t m;
        int   k;
        m = model_div(a, b, s);
        chk({name, "_model_q"}, m.q, eq);
        chk({name, "_model_r"}, m.r, er);
        chk({name, "_model_lat"}, {24'd0, m.lat}, elat);
        dividend  = a;
        divisor   = b;
        is_signed = s;
        start     = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        dividend = 32'd77;
        divisor  = 32'd5;
        k = 0;
        while (done !== 1'b1 && k < 100) begin
            if (k == glitch_k) start = 1'b1;
            @(negedge clk);
            k++;
            start = 1'b0;
        end
        chk({name, "_lat"}, k, elat);
        chk({name, "_q"}, quotient, eq);
        chk({name, "_r"}, remainder, er);
        chk({name, "_dz"}, {31'd0, div_by_zero}, {31'd0, edz});
    endtask

    initial begin
        int dcount;
        reset     = 1'b1;
        start     = 1'b0;
        is_signed = 1'b0;
        dividend  = 32'd0;
        divisor   = 32'd0;
        repeat (2) @(negedge clk);
        reset  = 1'b0;
        chk_en = 1'b1;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_q", quotient, 32'd0);
        chk("rst_r", remainder, 32'd0);
        chk("rst_dz", {31'd0, div_by_zero}, 32'd0);
        @(negedge clk);

        run_op("u100_7",  32'd100,        32'd7,          1'b0, 32'd14,         32'd2,          1'b0, 34, -1);
        run_op("sm100_7", 32'hFFFF_FF9C,  32'd7,          1'b1, 32'hFFFF_FFF2,  32'hFFFF_FFFE,  1'b0, 34, -1);
        run_op("s100_m7", 32'd100,        32'hFFFF_FFF9,  1'b1, 32'hFFFF_FFF2,  32'd2,          1'b0, 34, -1);
        run_op("sm100_m7",32'hFFFF_FF9C,  32'hFFFF_FFF9,  1'b1, 32'd14,         32'hFFFF_FFFE,  1'b0, 34, -1);
        run_op("dbz",     32'h1234_5678,  32'd0,          1'b0, 32'hFFFF_FFFF,  32'h1234_5678,  1'b1, 2,  -1);
        run_op("dbz_clr", 32'd100,        32'd7,          1'b0, 32'd14,         32'd2,          1'b0, 34, -1);
        run_op("ovf_s",   32'h8000_0000,  32'hFFFF_FFFF,  1'b1, 32'h8000_0000,  32'd0,          1'b0, 34, -1);
        run_op("ovf_u",   32'h8000_0000,  32'hFFFF_FFFF,  1'b0, 32'd0,          32'h8000_0000,  1'b0, EL, -1);
        run_op("ign_st",  32'd1000,       32'd3,          1'b0, 32'd333,        32'd1,          1'b0, 34, 4);
        run_op("u5_9",    32'd5,          32'd9,          1'b0, 32'd0,          32'd5,          1'b0, EL, -1);
        run_op("sm3_7",   32'hFFFF_FFFD,  32'd7,          1'b1, 32'd0,          32'hFFFF_FFFD,  1'b0, EL, -1);

        // Reset at edge N+10 aborts the operation without a done pulse.
        dividend  = 32'd1000;
        divisor   = 32'd3;
        is_signed = 1'b0;
        start     = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_done", {31'd0, done}, 32'd0);
        chk("abort_q", quotient, 32'd0);
        chk("abort_r", remainder, 32'd0);
        chk("abort_dz", {31'd0, div_by_zero}, 32'd0);
        dcount = 0;
        repeat (40) begin
            @(negedge clk);
            if (done === 1'b1) dcount++;
        end
        chk("abort_nodone", dcount, 32'd0);
        run_op("u9_2", 32'd9, 32'd2, 1'b0, 32'd4, 32'd1, 1'b0, 34, -1);

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
